// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment constants, digit decoder and converter state encoding
package sevenseg_pkg;
  typedef enum logic {IDLE, SHIFT} conv_state_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0: seg_decode = SEG_0;
      4'd1: seg_decode = SEG_1;
      4'd2: seg_decode = SEG_2;
      4'd3: seg_decode = SEG_3;
      4'd4: seg_decode = SEG_4;
      4'd5: seg_decode = SEG_5;
      4'd6: seg_decode = SEG_6;
      4'd7: seg_decode = SEG_7;
      4'd8: seg_decode = SEG_8;
      4'd9: seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter
//   Clk, Rst_n (sync active-low), Start (capture Bin when idle)
//   Busy (conversion running), Done (final shift this cycle), Bcd (result, valid with Done)
module bin2bcd_seq import sevenseg_pkg::*; #(
  parameter int BIN_WIDTH = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Start,
  input  logic [BIN_WIDTH-1:0]    Bin,
  output logic                    Busy,
  output logic                    Done,
  output logic [4*NUM_DIGITS-1:0] Bcd
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);
  conv_state_t state, state_n;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BW-1:0] bcd_q, adj;
  logic [CW-1:0] cnt;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    // the top bit of adj falls off: the work register only holds NUM_DIGITS nibbles
    Bcd = {adj[BW-2:0], bin_q[BIN_WIDTH-1]};
    Busy = state == SHIFT;
    Done = Busy && cnt == CW'(BIN_WIDTH - 1);
    state_n = state == IDLE ? (Start ? SHIFT : IDLE) : (Done ? IDLE : SHIFT);
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && Start) begin
        bin_q <= Bin;
        bcd_q <= '0;
        cnt <= '0;
      end else if (Busy) begin
        bcd_q <= Bcd;
        bin_q <= bin_q << 1;
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: multiplexed seven-segment driver with sequential BCD conversion
//   Clk, Rst_n (sync active-low), Value/Load (binary input and capture strobe), Dp (live decimal points)
//   Lz_blank (leading-zero blanking), Busy, Overflow, SevenSegment ([0]=a..[6]=g,[7]=dp), Enable (one-hot)
module sevenseg_scan_driver import sevenseg_pkg::*; #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH = 10,
  parameter int REFRESH_DIV = 12000,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [BIN_WIDTH-1:0]  Value,
  input  logic                  Load,
  input  logic [NUM_DIGITS-1:0] Dp,
  input  logic                  Lz_blank,
  output logic                  Busy,
  output logic                  Overflow,
  output logic [7:0]            SevenSegment,
  output logic [NUM_DIGITS-1:0] Enable
);
  localparam int unsigned MAX = 10**NUM_DIGITS - 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV + 1);
  logic busy, done, ovf_pend, ovf_q, blank;
  logic [4*NUM_DIGITS-1:0] bcd, bcd_q;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic [6:0] seg7;
  logic [7:0] seg_d;
  logic [NUM_DIGITS-1:0] en_d;
  bin2bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Load && !busy), .Bin(Value),
    .Busy(busy), .Done(done), .Bcd(bcd)
  );
  assign Busy = busy;
  assign Overflow = ovf_q;
  always_comb begin
    nib = bcd_q[4*idx +: 4];
    // blank when this nibble and everything above it is zero; digit 0 always shows
    blank = Lz_blank && idx != '0 && (bcd_q >> (4*idx)) == '0;
    seg7 = ovf_q ? SEG_DASH : blank ? SEG_BLANK : seg_decode(nib);
    seg_d = {Dp[idx], seg7} ^ {8{ACTIVE_LOW}};
    en_d = (NUM_DIGITS'(1) << idx) ^ {NUM_DIGITS{ACTIVE_LOW}};
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ovf_pend <= 1'b0;
      ovf_q <= 1'b0;
      bcd_q <= '0;
      pre <= '0;
      idx <= '0;
      SevenSegment <= {8{ACTIVE_LOW}};
      Enable <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      if (Load && !busy) ovf_pend <= 32'(Value) > MAX;
      if (done) begin
        bcd_q <= bcd;
        ovf_q <= ovf_pend;
      end
      pre <= pre == PW'(REFRESH_DIV - 1) ? '0 : pre + PW'(1);
      if (pre == PW'(REFRESH_DIV - 1)) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      SevenSegment <= seg_d;
      Enable <= en_d;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: randomized and directed checks against a decimal-arithmetic reference model
module tb_sevenseg_scan_driver;
  localparam int ND = 3;
  localparam int BW = 10;
  localparam int RD = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic [BW-1:0] value = '0;
  logic load = 0;
  logic [ND-1:0] dp = '0;
  logic lz = 0;
  logic busy, ovf;
  logic [7:0] seg;
  logic [ND-1:0] en;
  int total = 0;
  int bad = 0;
  bit checking = 0;
  int m_val = 0, m_pend = 0, m_left = 0, m_n = 0;
  bit m_ovf = 0;
  logic [7:0] e_seg = 8'hFF;
  logic [ND-1:0] e_en = '1;
  logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  sevenseg_scan_driver #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
    .Clk(clk), .Rst_n(rst_n), .Value(value), .Load(load), .Dp(dp), .Lz_blank(lz),
    .Busy(busy), .Overflow(ovf), .SevenSegment(seg), .Enable(en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] exp_seg(int i, int v, bit o, logic [ND-1:0] d, bit z);
    int p = 1;
    logic [6:0] s;
    for (int k = 0; k < i; k++) p *= 10;
    s = o ? 7'h40 : (z && i > 0 && v / p == 0) ? 7'h00 : tbl[(v / p) % 10];
    return ~{d[i], s};
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_val <= 0;
      m_ovf <= 0;
      m_left <= 0;
      m_n <= 0;
      e_seg <= 8'hFF;
      e_en <= '1;
    end else begin
      m_n <= m_n + 1;
      e_seg <= exp_seg((m_n / RD) % ND, m_val, m_ovf, dp, lz);
      e_en <= ~(ND'(1) << ((m_n / RD) % ND));
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_val <= m_pend % 1000;
          m_ovf <= m_pend > 999;
        end
      end else if (load) begin
        m_left <= BW;
        m_pend <= int'(value);
      end
    end
  end
  always @(negedge clk) begin
    if (checking) begin
      chk("seg", 32'(seg), 32'(e_seg));
      chk("en", 32'(en), 32'(e_en));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(input int v);
    @(negedge clk);
    value = BW'(v);
    load = 1;
    @(negedge clk);
    load = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  initial begin
    int n;
    cyc(3);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_en", 32'(en), 32'h7);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    checking = 1;
    rst_n = 1;
    cyc(1);
    chk("first_digit", 32'(seg), 32'hC0);
    chk("first_en", 32'(en), 32'h6);
    do_load(123);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 32'd10);
    cyc(3 * RD * 2);
    lz = 1;
    dp = 3'b010;
    do_load(7);
    wait_idle();
    cyc(3 * RD * 2);
    dp = 0;
    lz = 0;
    do_load(1000);
    wait_idle();
    chk("ovf_set", 32'(ovf), 32'd1);
    cyc(3 * RD);
    do_load(5);
    wait_idle();
    chk("ovf_clr", 32'(ovf), 32'd0);
    cyc(3 * RD);
    do_load(123);
    cyc(3);
    do_load(456);
    wait_idle();
    value = BW'(42);
    load = 1;
    @(negedge clk);
    load = 0;
    chk("accept_after_busy", 32'(busy), 32'd1);
    wait_idle();
    cyc(3 * RD);
    do_load(999);
    cyc(4);
    rst_n = 0;
    cyc(2);
    rst_n = 1;
    cyc(1);
    chk("abort_busy", 32'(busy), 32'd0);
    cyc(3 * RD * 2);
    for (int i = 0; i < 60; i++) begin
      dp = ND'($urandom);
      lz = 1'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 0;
        cyc(1);
        rst_n = 1;
      end
      do_load(int'($urandom_range(0, 1023)));
      cyc($urandom_range(0, 14));
    end
    wait_idle();
    cyc(3 * RD);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
